// File: rtl/bcd_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_sync_counter
//  Purpose  : Fully synchronous multi-digit modulo up/down counter with
//             parallel load, terminal-count flag, cascade carry and a
//             registered wrap pulse. Every flop is on the single clock.
//  Options  : BCD_CNT_SATURATE_EN - when defined, the counter holds at its
//             terminal value instead of wrapping, and wrap never asserts.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_sync_counter #(
  parameter int DIGITS = 2,   // number of 4-bit digits (1..8)
  parameter int MOD    = 10   // modulus of every digit (2..16)
) (
  input  logic                  clock,
  input  logic                  clear_in,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  carry_out,
  output logic                  wrap
);

  localparam int         W     = 4 * DIGITS;
  localparam logic [3:0] C_MAX = 4'(MOD - 1);
  localparam logic [4:0] C_MOD = 5'(MOD);
`ifdef BCD_CNT_SATURATE_EN
  localparam bit         C_SATURATE = 1'b1;
`else
  localparam bit         C_SATURATE = 1'b0;
`endif

  logic [W-1:0]      count_q;
  logic [W-1:0]      count_d;
  logic              wrap_q;
  logic              wrap_d;
  logic [DIGITS-1:0] dig_max;     // digit k sits at MOD-1
  logic [DIGITS-1:0] dig_zero;    // digit k sits at 0
  logic [DIGITS-1:0] move;        // digit k steps on a counting edge
  logic [W-1:0]      load_clean;  // load value with out-of-range nibbles zeroed
  logic [W-1:0]      stepped;     // count after one up/down step (wrapping)

  // Digit 0 always moves on a counting edge; higher digits need every lower
  // digit at its terminal value (MOD-1 going up, 0 going down).
  assign move[0] = 1'b1;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [3:0] cur;
      assign cur         = count_q[4*k +: 4];
      assign dig_max[k]  = (cur == C_MAX);
      assign dig_zero[k] = (cur == 4'd0);

      // A nibble outside 0..MOD-1 is loaded as 0 so digits stay in range.
      assign load_clean[4*k +: 4] =
        ({1'b0, load_val[4*k +: 4]} < C_MOD) ? load_val[4*k +: 4] : 4'd0;

      assign stepped[4*k +: 4] =
        !move[k] ? cur :
        up       ? (dig_max[k]  ? 4'd0  : cur + 4'd1) :
                   (dig_zero[k] ? C_MAX : cur - 4'd1);

      if (k < DIGITS - 1) begin : g_chain
        assign move[k+1] = move[k] & (up ? dig_max[k] : dig_zero[k]);
      end
    end
  endgenerate

  // Terminal count follows the live direction input, independent of en.
  assign tc        = up ? (&dig_max) : (&dig_zero);
  assign carry_out = tc & en & ~load & ~clear_in;

  // Next count: load beats counting; a terminal-count step wraps (or holds
  // when saturating) and flags a wrap for the following cycle.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_clean;
    end else if (en) begin
      if (tc && C_SATURATE) begin
        count_d = count_q;
      end else begin
        count_d = stepped;
        wrap_d  = tc;
      end
    end
  end

  // State register; clear_in is a synchronous reset with top priority.
  always_ff @(posedge clock) begin
    if (clear_in) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_sync_counter
//  Purpose  : Self-checking bench for bcd_sync_counter (DIGITS=2, MOD=10).
//             A value-level model (plain integer 0..99) predicts every
//             output; a cascaded pair of instances is modelled the same way.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_sync_counter;

  localparam int N = 100;  // states of one 2-digit decimal counter
`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clock;
  logic        clear_in;
  logic        en;
  logic        up;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  count;
  logic        tc;
  logic        carry_out;
  logic        wrap;

  logic        c_en;
  logic [15:0] c_lv;
  logic [7:0]  lo_count;
  logic [7:0]  hi_count;
  logic        lo_tc;
  logic        hi_tc;
  logic        lo_carry;
  logic        hi_carry;
  logic        lo_wrap;
  logic        hi_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int m_v    = 0;
  int m_lo   = 0;
  int m_hi   = 0;
  bit m_wrap = 1'b0;
  bit m_lo_wrap = 1'b0;
  bit m_hi_wrap = 1'b0;
  bit m_lc;

  bcd_sync_counter #(.DIGITS(2), .MOD(10)) dut (
    .clock(clock), .clear_in(clear_in), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .carry_out(carry_out),
    .wrap(wrap)
  );

  bcd_sync_counter #(.DIGITS(2), .MOD(10)) u_lo (
    .clock(clock), .clear_in(clear_in), .en(c_en), .up(up), .load(load),
    .load_val(c_lv[7:0]), .count(lo_count), .tc(lo_tc),
    .carry_out(lo_carry), .wrap(lo_wrap)
  );

  bcd_sync_counter #(.DIGITS(2), .MOD(10)) u_hi (
    .clock(clock), .clear_in(clear_in), .en(lo_carry), .up(up), .load(load),
    .load_val(c_lv[15:8]), .count(hi_count), .tc(hi_tc),
    .carry_out(hi_carry), .wrap(hi_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic int sanit(input logic [7:0] lv);
    int d1;
    int d0;
    d1 = int'(lv[7:4]);
    d0 = int'(lv[3:0]);
    if (d1 > 9) d1 = 0;
    if (d0 > 9) d0 = 0;
    return d1 * 10 + d0;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'(v / 10);
    b = 4'(v % 10);
    return {a, b};
  endfunction

  function automatic bit term(input int v, input bit u);
    return u ? (v == N - 1) : (v == 0);
  endfunction

  function automatic int nxt(input int v, input bit e, input bit u,
                             input bit ld, input bit clr, input logic [7:0] lv);
    if (clr) return 0;
    if (ld)  return sanit(lv);
    if (!e)  return v;
    if (u)   return (v == N - 1) ? (SAT ? v : 0) : v + 1;
    return (v == 0) ? (SAT ? 0 : N - 1) : v - 1;
  endfunction

  always @(posedge clock) begin
    m_lc      = term(m_lo, up) && c_en && !load && !clear_in;
    m_wrap    = !SAT && !clear_in && !load && en && term(m_v, up);
    m_lo_wrap = !SAT && m_lc;
    m_hi_wrap = !SAT && m_lc && term(m_hi, up);
    m_v  = nxt(m_v,  en,   up, load, clear_in, load_val);
    m_hi = nxt(m_hi, m_lc, up, load, clear_in, c_lv[15:8]);
    m_lo = nxt(m_lo, c_en, up, load, clear_in, c_lv[7:0]);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle compare all outputs against the model, away from the edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count",     32'(count), 32'(to_bcd(m_v)));
      check("tc",        32'(tc), 32'(term(m_v, up)));
      check("carry_out", 32'(carry_out),
            32'(term(m_v, up) && en && !load && !clear_in));
      check("wrap",      32'(wrap), 32'(m_wrap));
      check("chain_count", {16'd0, hi_count, lo_count},
            {16'd0, to_bcd(m_hi), to_bcd(m_lo)});
      check("lo_tc",     32'(lo_tc), 32'(term(m_lo, up)));
      check("hi_tc",     32'(hi_tc), 32'(term(m_hi, up)));
      check("lo_carry",  32'(lo_carry),
            32'(term(m_lo, up) && c_en && !load && !clear_in));
      check("hi_carry",  32'(hi_carry),
            32'(term(m_hi, up) && term(m_lo, up) && c_en && !load && !clear_in));
      check("lo_wrap",   32'(lo_wrap), 32'(m_lo_wrap));
      check("hi_wrap",   32'(hi_wrap), 32'(m_hi_wrap));
    end
  end

  // Apply inputs, then advance to just after the next rising edge.
  task automatic drive(input bit clr, input bit ld, input bit e, input bit u,
                       input logic [7:0] lv);
    clear_in = clr;
    load     = ld;
    en       = e;
    up       = u;
    load_val = lv;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_in = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h45;
    c_en = 1'b0; c_lv = 16'h0000;

    // 1. reset overrides load and en
    drive(1, 1, 1, 1, 8'h45);
    chk_en = 1'b1;
    drive(1, 1, 1, 1, 8'h45);
    check("t1_reset_count", 32'(count), 32'h00);
    check("t1_reset_wrap",  32'(wrap), 32'h0);
    drive(0, 0, 1, 1, 8'h00);
    check("t1_first_count", 32'(count), 32'h01);

    // 2. count up to 99, then wrap (or hold when saturating)
    repeat (98) drive(0, 0, 1, 1, 8'h00);
    check("t2_at_99",    32'(count), 32'h99);
    check("t2_tc",       32'(tc), 32'h1);
    check("t2_carry",    32'(carry_out), 32'h1);
    drive(0, 0, 1, 1, 8'h00);
    check("t2_wrap_count", 32'(count), SAT ? 32'h99 : 32'h00);
    check("t2_wrap_pulse", 32'(wrap), SAT ? 32'h0 : 32'h1);
    drive(0, 0, 1, 1, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    check("t2_wrap_drop", 32'(wrap), 32'h0);

    // 3. borrow across digits, and down-wrap from 00
    drive(0, 1, 0, 0, 8'h10);
    drive(0, 0, 1, 0, 8'h00);
    check("t3_borrow", 32'(count), 32'h09);
    drive(0, 1, 0, 0, 8'h00);
    check("t3_tc_zero", 32'(tc), 32'h1);
    drive(0, 0, 1, 0, 8'h00);
    check("t3_down_wrap",  32'(count), SAT ? 32'h00 : 32'h99);
    check("t3_down_pulse", 32'(wrap), SAT ? 32'h0 : 32'h1);

    // 4. load sanitising and load-over-en priority, then hold
    drive(0, 1, 1, 1, 8'h3C);
    check("t4_sanitise", 32'(count), 32'h30);
    check("t4_load_wrap", 32'(wrap), 32'h0);
    repeat (5) drive(0, 0, 0, 1, 8'h00);
    check("t4_hold", 32'(count), 32'h30);

    // 5. direction flip, combinational tc, cascade
    drive(0, 1, 0, 1, 8'h19);
    drive(0, 0, 1, 0, 8'h00);
    check("t5_flip", 32'(count), 32'h18);
    drive(0, 1, 0, 1, 8'h99);
    check("t5_tc_up", 32'(tc), 32'h1);
    up = 1'b0;
    #1;
    check("t5_tc_flip", 32'(tc), 32'h0);
    c_lv = 16'h0999;
    drive(0, 1, 0, 1, 8'h00);
    c_en = 1'b1;
    drive(0, 0, 0, 1, 8'h00);
    check("t5_cascade", {16'd0, hi_count, lo_count}, SAT ? 32'h1099 : 32'h1000);
    c_en = 1'b0;

    // 6. randomized traffic against the model
    repeat (3000) begin
      c_en = ($urandom % 4) != 0;
      c_lv = 16'($urandom);
      drive(($urandom % 60) == 0, ($urandom % 12) == 0, ($urandom % 10) < 8,
            ($urandom % 3) != 0, 8'($urandom));
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
